// File: rtl/cache_line_bus_arbiter_if.sv
// Line-bus bundle between ICache/DCache line masters, the arbiter and the AXI bridge slave port.
// master: the arbiter's view; slave: the surrounding caches and bridge.
interface cache_line_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
);
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              i_rd_rdy;
  logic              i_ret_valid;
  logic [LINE_W-1:0] i_ret_data;

  logic              d_rd_req;
  logic [ADDR_W-1:0] d_rd_addr;
  logic              d_rd_rdy;
  logic              d_ret_valid;
  logic [LINE_W-1:0] d_ret_data;
  logic              d_wr_req;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [LINE_W-1:0] d_wr_data;
  logic              d_wr_rdy;
  logic              d_wr_valid;

  logic              m_rd_req;
  logic [ADDR_W-1:0] m_rd_addr;
  logic              m_rd_rdy;
  logic              m_ret_valid;
  logic [LINE_W-1:0] m_ret_data;
  logic              m_wr_req;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [LINE_W-1:0] m_wr_data;
  logic              m_wr_rdy;
  logic              m_wr_valid;

  modport master (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr, d_wr_req, d_wr_addr, d_wr_data,
    input  m_rd_rdy, m_ret_valid, m_ret_data, m_wr_rdy, m_wr_valid,
    output i_rd_rdy, i_ret_valid, i_ret_data, d_rd_rdy, d_ret_valid, d_ret_data,
    output d_wr_rdy, d_wr_valid,
    output m_rd_req, m_rd_addr, m_wr_req, m_wr_addr, m_wr_data
  );

  modport slave (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr, d_wr_req, d_wr_addr, d_wr_data,
    output m_rd_rdy, m_ret_valid, m_ret_data, m_wr_rdy, m_wr_valid,
    input  i_rd_rdy, i_ret_valid, i_ret_data, d_rd_rdy, d_ret_valid, d_ret_data,
    input  d_wr_rdy, d_wr_valid,
    input  m_rd_req, m_rd_addr, m_wr_req, m_wr_addr, m_wr_data
  );
endinterface

// File: rtl/cache_line_bus_arbiter.sv
// Serialises ICache/DCache line refills and DCache writebacks onto one bridge port.
// Writeback has priority; reads round-robin between I and D, one transaction outstanding.
module cache_line_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic clk,
  input  logic resetn,
  cache_line_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0] wr_data_q, wr_data_d;
  logic              grant_i, grant_d, grant_w;

  // State and latched transaction registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      rr_last_q <= OWN_D;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state and grant selection; writes never touch rr_last
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    grant_w   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.d_wr_req) begin
          grant_w   = 1'b1;
          wr_addr_d = bus.d_wr_addr;
          wr_data_d = bus.d_wr_data;
          state_d   = WR_REQ;
        end else if (bus.i_rd_req && (!bus.d_rd_req || rr_last_q == OWN_D)) begin
          grant_i   = 1'b1;
          rd_addr_d = bus.i_rd_addr;
          owner_d   = OWN_I;
          rr_last_d = OWN_I;
          state_d   = RD_REQ;
        end else if (bus.d_rd_req) begin
          grant_d   = 1'b1;
          rd_addr_d = bus.d_rd_addr;
          owner_d   = OWN_D;
          rr_last_d = OWN_D;
          state_d   = RD_REQ;
        end
      end
      RD_REQ:  if (bus.m_rd_rdy)    state_d = RD_WAIT;
      RD_WAIT: if (bus.m_ret_valid) state_d = IDLE;
      WR_REQ:  if (bus.m_wr_rdy)    state_d = WR_WAIT;
      WR_WAIT: if (bus.m_wr_valid)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Upstream handshakes; gated by resetn so nothing leaks out while reset is held
  always_comb begin
    bus.i_rd_rdy    = 1'b0;
    bus.d_rd_rdy    = 1'b0;
    bus.d_wr_rdy    = 1'b0;
    bus.i_ret_valid = 1'b0;
    bus.d_ret_valid = 1'b0;
    bus.d_wr_valid  = 1'b0;
    if (resetn) begin
      bus.i_rd_rdy    = grant_i;
      bus.d_rd_rdy    = grant_d;
      bus.d_wr_rdy    = grant_w;
      bus.i_ret_valid = (state_q == RD_WAIT) && (owner_q == OWN_I) && bus.m_ret_valid;
      bus.d_ret_valid = (state_q == RD_WAIT) && (owner_q == OWN_D) && bus.m_ret_valid;
      bus.d_wr_valid  = (state_q == WR_WAIT) && bus.m_wr_valid;
    end
  end

  // Downstream request side comes straight from registers
  assign bus.m_rd_req   = (state_q == RD_REQ);
  assign bus.m_rd_addr  = rd_addr_q;
  assign bus.m_wr_req   = (state_q == WR_REQ);
  assign bus.m_wr_addr  = wr_addr_q;
  assign bus.m_wr_data  = wr_data_q;
  assign bus.i_ret_data = bus.m_ret_data;
  assign bus.d_ret_data = bus.m_ret_data;

endmodule

// File: tb/tb_cache_line_bus_arbiter.sv
// Directed bench for cache_line_bus_arbiter: inputs driven on negedge, outputs checked 1ns later.
module tb_cache_line_bus_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  cache_line_bus_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_line_bus_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  localparam logic [LINE_W-1:0] RET_A  = {4{32'hA5A5_A5A5}};
  localparam logic [LINE_W-1:0] W_DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {i_rd_rdy, d_rd_rdy, d_wr_rdy, i_ret_valid, d_ret_valid, d_wr_valid}
  function automatic logic [5:0] ups();
    return {bus.i_rd_rdy, bus.d_rd_rdy, bus.d_wr_rdy, bus.i_ret_valid, bus.d_ret_valid, bus.d_wr_valid};
  endfunction

  task automatic chk_u(input string tag, input logic [5:0] exp);
    chk(tag, LINE_W'(ups()), LINE_W'(exp));
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    chk(tag, LINE_W'(obs), LINE_W'(exp));
  endtask

  task automatic chk_a(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    chk(tag, LINE_W'(obs), LINE_W'(exp));
  endtask

  task automatic clear_inputs();
    bus.i_rd_req = 1'b0; bus.i_rd_addr = '0;
    bus.d_rd_req = 1'b0; bus.d_rd_addr = '0;
    bus.d_wr_req = 1'b0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
    bus.m_rd_rdy = 1'b0; bus.m_ret_valid = 1'b0; bus.m_ret_data = '0;
    bus.m_wr_rdy = 1'b0; bus.m_wr_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();

    // Reset: outputs quiet even with requests present
    repeat (2) @(negedge clk);
    bus.i_rd_req = 1'b1; bus.d_rd_req = 1'b1; bus.d_wr_req = 1'b1;
    #1;
    chk_u("rst_upstream", 6'b000000);
    chk_b("rst_m_rd_req", bus.m_rd_req, 1'b0);
    chk_b("rst_m_wr_req", bus.m_wr_req, 1'b0);
    chk_a("rst_m_rd_addr", bus.m_rd_addr, '0);
    chk_a("rst_m_wr_addr", bus.m_wr_addr, '0);
    chk("rst_m_wr_data", bus.m_wr_data, '0);
    clear_inputs();
    @(negedge clk); resetn = 1'b1;

    // Single I read
    @(negedge clk); bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h1FC0_0000; #1;
    chk_u("t1_grant", 6'b100000);
    @(negedge clk); bus.i_rd_req = 1'b0; bus.m_rd_rdy = 1'b1; #1;
    chk_b("t1_m_rd_req", bus.m_rd_req, 1'b1);
    chk_a("t1_m_rd_addr", bus.m_rd_addr, 32'h1FC0_0000);
    chk_u("t1_no_rdy", 6'b000000);
    @(negedge clk); bus.m_rd_rdy = 1'b0; bus.m_ret_valid = 1'b1; bus.m_ret_data = RET_A; #1;
    chk_u("t1_ret", 6'b000100);
    chk("t1_ret_data", bus.i_ret_data, RET_A);
    chk_b("t1_m_rd_req_drop", bus.m_rd_req, 1'b0);
    @(negedge clk); #1;
    chk_u("t1_idle_spurious", 6'b000000);
    bus.m_ret_valid = 1'b0;

    // Tie round-robin from reset: I, D, I, D
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h0000_1000;
    bus.d_rd_req = 1'b1; bus.d_rd_addr = 32'h0000_2000;
    bus.m_rd_rdy = 1'b1; bus.m_ret_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_u($sformatf("t2_grant%0d", k), (k % 2 == 0) ? 6'b100000 : 6'b010000);
      @(negedge clk); #1;
      chk_b($sformatf("t2_req%0d", k), bus.m_rd_req, 1'b1);
      chk_a($sformatf("t2_addr%0d", k), bus.m_rd_addr, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      @(negedge clk); bus.m_ret_data = LINE_W'(32'h100 + k); #1;
      chk_u($sformatf("t2_ret%0d", k), (k % 2 == 0) ? 6'b000100 : 6'b000010);
      chk($sformatf("t2_data%0d", k), (k % 2 == 0) ? bus.i_ret_data : bus.d_ret_data, LINE_W'(32'h100 + k));
      @(negedge clk);
    end

    // Writeback priority over both reads; rr_last is D so I reads next
    bus.d_wr_req = 1'b1; bus.d_wr_addr = 32'h8000_0040; bus.d_wr_data = W_DATA;
    bus.d_rd_addr = 32'h8000_0040; bus.i_rd_addr = 32'h1FC0_0040;
    bus.m_wr_rdy = 1'b1; bus.m_wr_valid = 1'b1;
    #1;
    chk_u("t3_wr_first", 6'b001000);
    @(negedge clk); bus.d_wr_req = 1'b0; #1;
    chk_b("t3_m_wr_req", bus.m_wr_req, 1'b1);
    chk_a("t3_m_wr_addr", bus.m_wr_addr, 32'h8000_0040);
    chk("t3_m_wr_data", bus.m_wr_data, W_DATA);
    chk_b("t3_no_m_rd", bus.m_rd_req, 1'b0);
    chk_u("t3_stalled", 6'b000000);
    @(negedge clk); #1;
    chk_u("t3_wr_valid", 6'b000001);
    chk_b("t3_m_wr_drop", bus.m_wr_req, 1'b0);
    @(negedge clk); #1;
    chk_u("t3_i_after_wr", 6'b100000);
    @(negedge clk); bus.i_rd_req = 1'b0; #1;
    chk_a("t3_i_addr", bus.m_rd_addr, 32'h1FC0_0040);
    @(negedge clk); bus.m_ret_data = RET_A; #1;
    chk_u("t3_i_ret", 6'b000100);
    @(negedge clk); #1;
    chk_u("t3_d_grant", 6'b010000);
    @(negedge clk); bus.d_rd_req = 1'b0; #1;
    chk_a("t3_d_addr", bus.m_rd_addr, 32'h8000_0040);
    @(negedge clk); #1;
    chk_u("t3_d_ret", 6'b000010);

    // Downstream stall with spurious return data and held requests
    @(negedge clk);
    bus.m_rd_rdy = 1'b0; bus.m_wr_rdy = 1'b0; bus.m_wr_valid = 1'b0; bus.m_ret_valid = 1'b1;
    bus.d_rd_req = 1'b1; bus.d_rd_addr = 32'h0000_1230;
    #1;
    chk_u("t4_grant", 6'b010000);
    @(negedge clk);
    bus.d_rd_req = 1'b0; bus.i_rd_req = 1'b1; bus.d_wr_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_b($sformatf("t4_req%0d", c), bus.m_rd_req, 1'b1);
      chk_a($sformatf("t4_addr%0d", c), bus.m_rd_addr, 32'h0000_1230);
      chk_u($sformatf("t4_quiet%0d", c), 6'b000000);
      @(negedge clk);
    end
    bus.m_rd_rdy = 1'b1; bus.m_ret_valid = 1'b0; #1;
    chk_b("t4_req_accept", bus.m_rd_req, 1'b1);
    @(negedge clk); bus.m_rd_rdy = 1'b0; #1;
    chk_b("t4_wait_req", bus.m_rd_req, 1'b0);
    chk_u("t4_wait_quiet", 6'b000000);

    // Reset in RD_WAIT as the line arrives: no pulse, outputs cleared immediately
    @(negedge clk); bus.m_ret_valid = 1'b1; resetn = 1'b0; #1;
    chk_u("t5_rst_quiet", 6'b000000);
    chk_b("t5_rst_m_rd_req", bus.m_rd_req, 1'b0);
    chk_a("t5_rst_addr", bus.m_rd_addr, '0);
    @(negedge clk);
    resetn = 1'b1; bus.m_ret_valid = 1'b0; bus.d_wr_req = 1'b0;
    bus.i_rd_req = 1'b1; bus.i_rd_addr = 32'h0000_4440;
    #1;
    chk_u("t5_grant_after_rst", 6'b100000);
    @(negedge clk); bus.i_rd_req = 1'b0; #1;
    chk_b("t5_m_rd_req", bus.m_rd_req, 1'b1);
    chk_a("t5_m_rd_addr", bus.m_rd_addr, 32'h0000_4440);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_line_bus_arbiter.md
Name: cache_line_bus_arbiter

Overview:
- Shares the single cache-line refill/writeback port of the AXI bridge between the ICache (line reads only) and the DCache (line reads and dirty-line writebacks).
- Sits between the two caches' line-bus master sides and the AXI bridge slave side.
- Serialises traffic so at most one line transaction is outstanding downstream.
- Priority: DCache writeback first, then round-robin between I and D reads.

Parameters:
ADDR_W, 32, line address width
LINE_W, 128, cache line data width (4 words)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
i_rd_req  in  1  ICache line read request
i_rd_addr  in  ADDR_W  ICache read address
i_rd_rdy  out  1  ICache request accepted (one-cycle grant)
i_ret_valid  out  1  ICache line returned (one-cycle pulse)
i_ret_data  out  LINE_W  returned line to ICache
d_rd_req  in  1  DCache line read request
d_rd_addr  in  ADDR_W  DCache read address
d_rd_rdy  out  1  DCache read accepted
d_ret_valid  out  1  DCache line returned
d_ret_data  out  LINE_W  returned line to DCache
d_wr_req  in  1  DCache writeback request
d_wr_addr  in  ADDR_W  writeback address
d_wr_data  in  LINE_W  writeback line
d_wr_rdy  out  1  writeback accepted
d_wr_valid  out  1  writeback completed (pulse)
m_rd_req  out  1  downstream read request
m_rd_addr  out  ADDR_W  downstream read address
m_rd_rdy  in  1  downstream accepts read
m_ret_valid  in  1  downstream line valid
m_ret_data  in  LINE_W  downstream line data
m_wr_req  out  1  downstream write request
m_wr_addr  out  ADDR_W  downstream write address
m_wr_data  out  LINE_W  downstream write data
m_wr_rdy  in  1  downstream accepts write
m_wr_valid  in  1  downstream write done

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on resetn.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- Registers: owner (I/D), latched addr/data, rr_last.
- Reset (async, resetn=0):
  - state=IDLE, rr_last=D (I wins the first tie).
  - m_rd_req=m_wr_req=0, m_rd_addr=m_wr_addr=0, m_wr_data=0.
  - All upstream rdy/valid outputs 0.
- IDLE grant, combinational, at most one rdy high per cycle:
  - d_wr_req=1: d_wr_rdy=1; latch d_wr_addr and d_wr_data; next state WR_REQ.
  - else only one read request present: that requester's rd_rdy=1.
  - else both reads present: grant the requester that is not rr_last.
  - On any read grant: latch the address, set owner, set rr_last=owner, next state RD_REQ.
- Upstream rdy outputs are 0 in every non-IDLE state; requests held there are stalled, not dropped.
- RD_REQ:
  - m_rd_req=1 and m_rd_addr=latched address; both stay stable until m_rd_rdy.
  - m_rd_rdy=1 -> RD_WAIT; m_rd_req drops the next cycle.
- RD_WAIT:
  - On m_ret_valid=1, owner's ret_valid=1 in the same cycle (combinational); then IDLE.
  - i_ret_data and d_ret_data are always driven with m_ret_data; only the valid is gated.
- WR_REQ: m_wr_req=1 with the latched addr/data until m_wr_rdy -> WR_WAIT.
- WR_WAIT: m_wr_valid=1 -> d_wr_valid=1 in the same cycle; then IDLE.
- m_ret_valid outside RD_WAIT and m_wr_valid outside WR_WAIT are ignored; no pulse is forwarded.
- Latency, grant in cycle T with immediate downstream rdy/valid:
  - m_*_req high T+1; response pulse at T+2; IDLE at T+3.
  - Next grant possible at T+3, so minimum 3 cycles per transaction.
- Writeback vs read conflict: a simultaneous d_wr_req and d_rd_req always run writeback first, so a read never overtakes a pending dirty-line write.
- A request deasserted before its grant is simply not granted; no state change.
- Reset mid-transaction: immediate return to IDLE, downstream reqs deasserted asynchronously, no response pulse is generated; the caches are also reset.
- Writes do not update rr_last.

Test Plan:
- Single I read: i_rd_req=1 addr 0x1FC0_0000 at T; m_rd_rdy=1 at T+1; m_ret_valid with data 0xA5.. at T+2 -> i_rd_rdy@T, m_rd_addr=0x1FC0_0000@T+1, i_ret_valid@T+2 with data matching, d_ret_valid stays 0.
- Tie round-robin: i_rd_req and d_rd_req held continuously from reset -> grant order I, D, I, D; each response reaches only its owner.
- Writeback priority: d_wr_req (addr 0x8000_0040) and d_rd_req (0x8000_0040) together with i_rd_req -> write granted first, m_wr_data equals d_wr_data, d_wr_valid pulse; then reads proceed I then D.
- Downstream stall: m_rd_rdy low for 5 cycles -> m_rd_req and m_rd_addr held stable; all upstream rdy=0 throughout; spurious m_ret_valid during RD_REQ is ignored.
- Reset mid-op: resetn=0 in RD_WAIT -> m_rd_req=0 and all outputs 0 immediately; after release a new i_rd_req is granted in its first cycle.
